// File: rtl/hazard_override_sequencer.sv
// Hazard override sequencer: turns stall/flush requests into pipeline stall/flush
// commands. It escalates long stalls to flushes, times out unacknowledged flushes and
// enforces a cooldown after each flush.
module hazard_override_sequencer #(
    parameter int STALL_MAX       = 16,
    parameter int FLUSH_TIMEOUT   = 32,
    parameter int COOLDOWN_CYCLES = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        override_flush_sig,
    input  logic        override_stall_sig,
    input  logic [1:0]  hazard_detected_level,
    input  logic        flush_ack,
    output logic        pipeline_stall,
    output logic        pipeline_flush,
    output logic [1:0]  seq_state,
    output logic [1:0]  active_level,
    output logic [15:0] flush_count,
    output logic [7:0]  escalation_count,
    output logic        flush_timeout_err,
    output logic        seq_busy
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        STALL    = 2'd1,
        FLUSH    = 2'd2,
        COOLDOWN = 2'd3
    } state_t;

    localparam logic [7:0] STALL_LAST = 8'(STALL_MAX - 1);
    localparam logic [7:0] FLUSH_LAST = 8'(FLUSH_TIMEOUT - 1);
    localparam logic [7:0] COOL_LAST  = 8'(COOLDOWN_CYCLES - 1);

    state_t      state_q, state_d;
    logic [7:0]  stall_cnt_q, stall_cnt_d;
    logic [7:0]  flush_timer_q, flush_timer_d;
    logic [7:0]  cool_cnt_q, cool_cnt_d;
    logic [1:0]  level_q, level_d;
    logic [15:0] flush_count_q, flush_count_d;
    logic [7:0]  esc_count_q, esc_count_d;
    logic        err_q, err_d;
    logic        stall_q, flush_q, busy_q;

    always_comb begin
        state_d       = state_q;
        stall_cnt_d   = stall_cnt_q;
        flush_timer_d = flush_timer_q;
        cool_cnt_d    = cool_cnt_q;
        level_d       = level_q;
        flush_count_d = flush_count_q;
        esc_count_d   = esc_count_q;
        err_d         = err_q;

        case (state_q)
            IDLE: begin
                if (override_flush_sig)      state_d = FLUSH;
                else if (override_stall_sig) state_d = STALL;
            end
            STALL: begin
                if (override_flush_sig) begin
                    state_d = FLUSH;
                end else if (!override_stall_sig) begin
                    state_d = IDLE;
                end else if (stall_cnt_q == STALL_LAST) begin
                    state_d = FLUSH;
                    if (esc_count_q != 8'hFF) esc_count_d = esc_count_q + 8'd1;
                end else begin
                    stall_cnt_d = stall_cnt_q + 8'd1;
                end
            end
            FLUSH: begin
                // Requests are ignored here; only ack or timeout leave FLUSH.
                if (flush_ack) begin
                    state_d = COOLDOWN;
                end else if (flush_timer_q == FLUSH_LAST) begin
                    state_d = COOLDOWN;
                    err_d   = 1'b1;
                end else begin
                    flush_timer_d = flush_timer_q + 8'd1;
                end
            end
            COOLDOWN: begin
                if (override_flush_sig && hazard_detected_level == 2'b11) begin
                    state_d = FLUSH;
                end else if (cool_cnt_q == COOL_LAST) begin
                    state_d = IDLE;
                end else begin
                    cool_cnt_d = cool_cnt_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        // No state has a self-transition that counts as a re-entry, so a change of state is an entry.
        if (state_d != state_q) begin
            case (state_d)
                IDLE: level_d = 2'd0;
                STALL: begin
                    stall_cnt_d = 8'd0;
                    level_d     = hazard_detected_level;
                end
                FLUSH: begin
                    flush_timer_d = 8'd0;
                    level_d       = hazard_detected_level;
                    if (flush_count_q != 16'hFFFF) flush_count_d = flush_count_q + 16'd1;
                end
                COOLDOWN: cool_cnt_d = 8'd0;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            stall_cnt_q   <= 8'd0;
            flush_timer_q <= 8'd0;
            cool_cnt_q    <= 8'd0;
            level_q       <= 2'd0;
            flush_count_q <= 16'd0;
            esc_count_q   <= 8'd0;
            err_q         <= 1'b0;
            stall_q       <= 1'b0;
            flush_q       <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            stall_cnt_q   <= stall_cnt_d;
            flush_timer_q <= flush_timer_d;
            cool_cnt_q    <= cool_cnt_d;
            level_q       <= level_d;
            flush_count_q <= flush_count_d;
            esc_count_q   <= esc_count_d;
            err_q         <= err_d;
            stall_q       <= (state_d == STALL);
            flush_q       <= (state_d == FLUSH);
            busy_q        <= (state_d != IDLE);
        end
    end

    assign pipeline_stall    = stall_q;
    assign pipeline_flush    = flush_q;
    assign seq_state         = state_q;
    assign active_level      = level_q;
    assign flush_count       = flush_count_q;
    assign escalation_count  = esc_count_q;
    assign flush_timeout_err = err_q;
    assign seq_busy          = busy_q;

endmodule

// File: tb/tb_hazard_override_sequencer.sv
// Self-checking bench for hazard_override_sequencer: vector table plus hand sequences,
// with expected outputs queued at drive time and compared one cycle later.
module tb_hazard_override_sequencer;

    logic        clk, rst;
    logic        fl_s, st_s, ack_s;
    logic [1:0]  lvl_s;
    logic        p_stall, p_flush, err, busy;
    logic [1:0]  sstate, alvl;
    logic [15:0] fcnt;
    logic [7:0]  ecnt;

    int n_assert = 0;
    int n_fail   = 0;
    string tag;

    hazard_override_sequencer #(.STALL_MAX(16), .FLUSH_TIMEOUT(32), .COOLDOWN_CYCLES(8)) dut (
        .clk(clk), .rst(rst),
        .override_flush_sig(fl_s), .override_stall_sig(st_s),
        .hazard_detected_level(lvl_s), .flush_ack(ack_s),
        .pipeline_stall(p_stall), .pipeline_flush(p_flush),
        .seq_state(sstate), .active_level(alvl),
        .flush_count(fcnt), .escalation_count(ecnt),
        .flush_timeout_err(err), .seq_busy(busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [1:0]  st;
        logic [1:0]  lvl;
        logic [15:0] fc;
        logic [7:0]  ec;
        logic        err;
    } exp_t;

    typedef struct {
        logic        fl, st, ak;
        logic [1:0]  lv;
        logic [1:0]  est, elv;
        logic [15:0] efc;
    } vec_t;

    exp_t sbq[$];
    vec_t tbl[25];

    function automatic vec_t mk(input logic fl, input logic st, input logic [1:0] lv, input logic ak,
                                input logic [1:0] est, input logic [1:0] elv, input logic [15:0] efc);
        vec_t v;
        v.fl = fl; v.st = st; v.lv = lv; v.ak = ak;
        v.est = est; v.elv = elv; v.efc = efc;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s %s: got %0h expected %0h at %0t", tag, nm, act, exp, $time);
        end
    endtask

    task automatic check_out(input exp_t e);
        chk("seq_state", {14'd0, sstate}, {14'd0, e.st});
        chk("pipeline_stall", {15'd0, p_stall}, {15'd0, (e.st == 2'd1)});
        chk("pipeline_flush", {15'd0, p_flush}, {15'd0, (e.st == 2'd2)});
        chk("seq_busy", {15'd0, busy}, {15'd0, (e.st != 2'd0)});
        chk("active_level", {14'd0, alvl}, {14'd0, e.lvl});
        chk("flush_count", fcnt, e.fc);
        chk("escalation_count", {8'd0, ecnt}, {8'd0, e.ec});
        chk("flush_timeout_err", {15'd0, err}, {15'd0, e.err});
    endtask

    task automatic step(input logic fl, input logic st, input logic [1:0] lv, input logic ak,
                        input logic [1:0] est, input logic [1:0] elv, input logic [15:0] efc,
                        input logic [7:0] eec, input logic eerr);
        exp_t e;
        fl_s = fl; st_s = st; lvl_s = lv; ack_s = ak;
        e.st = est; e.lvl = elv; e.fc = efc; e.ec = eec; e.err = eerr;
        sbq.push_back(e);
        @(posedge clk);
        #1;
        e = sbq.pop_front();
        check_out(e);
    endtask

    task automatic chk_zero();
        chk("rst seq_state", {14'd0, sstate}, 16'd0);
        chk("rst pipeline_stall", {15'd0, p_stall}, 16'd0);
        chk("rst pipeline_flush", {15'd0, p_flush}, 16'd0);
        chk("rst seq_busy", {15'd0, busy}, 16'd0);
        chk("rst active_level", {14'd0, alvl}, 16'd0);
        chk("rst flush_count", fcnt, 16'd0);
        chk("rst escalation_count", {8'd0, ecnt}, 16'd0);
        chk("rst flush_timeout_err", {15'd0, err}, 16'd0);
    endtask

    // Assert reset between edges and confirm outputs drop without a clock edge.
    task automatic mid_reset();
        rst = 1'b1;
        #1;
        chk_zero();
        fl_s = 1'b0; st_s = 1'b0; lvl_s = 2'd0; ack_s = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; fl_s = 1'b0; st_s = 1'b0; lvl_s = 2'd0; ack_s = 1'b0;

        //            fl st lv ak  est elv fc
        tbl[0]  = mk(0, 0, 0, 0, 0, 0, 0);
        tbl[1]  = mk(0, 1, 1, 0, 1, 1, 0);
        tbl[2]  = mk(0, 1, 2, 0, 1, 1, 0);
        tbl[3]  = mk(0, 1, 2, 0, 1, 1, 0);
        tbl[4]  = mk(0, 0, 0, 0, 0, 0, 0);
        tbl[5]  = mk(1, 1, 2, 0, 2, 2, 1);
        tbl[6]  = mk(1, 0, 2, 0, 2, 2, 1);
        tbl[7]  = mk(0, 0, 0, 0, 2, 2, 1);
        tbl[8]  = mk(0, 0, 0, 0, 2, 2, 1);
        tbl[9]  = mk(0, 0, 0, 0, 2, 2, 1);
        tbl[10] = mk(0, 0, 0, 1, 3, 2, 1);
        tbl[11] = mk(0, 1, 1, 0, 3, 2, 1);
        tbl[12] = mk(1, 0, 2, 0, 3, 2, 1);
        tbl[13] = mk(0, 0, 0, 1, 3, 2, 1);
        tbl[14] = mk(0, 0, 0, 0, 3, 2, 1);
        tbl[15] = mk(0, 0, 0, 0, 3, 2, 1);
        tbl[16] = mk(0, 0, 0, 0, 3, 2, 1);
        tbl[17] = mk(0, 0, 0, 0, 3, 2, 1);
        tbl[18] = mk(0, 0, 0, 0, 0, 0, 1);
        tbl[19] = mk(1, 0, 3, 0, 2, 3, 2);
        tbl[20] = mk(0, 0, 0, 1, 3, 3, 2);
        tbl[21] = mk(1, 1, 3, 0, 2, 3, 3);
        tbl[22] = mk(0, 0, 0, 1, 3, 3, 3);
        tbl[23] = mk(1, 0, 2, 0, 3, 3, 3);
        tbl[24] = mk(0, 1, 0, 0, 3, 3, 3);

        tag = "reset";
        repeat (2) @(posedge clk);
        fl_s = 1'b1; st_s = 1'b1; lvl_s = 2'd3;
        @(posedge clk);
        #1;
        chk_zero();
        fl_s = 1'b0; st_s = 1'b0; lvl_s = 2'd0;
        @(negedge clk);
        rst = 1'b0;

        // Short stall, flush with ack on 5th cycle, cooldown filtering and preemption.
        for (int i = 0; i < 25; i++) begin
            tag = $sformatf("table[%0d]", i);
            step(tbl[i].fl, tbl[i].st, tbl[i].lv, tbl[i].ak,
                 tbl[i].est, tbl[i].elv, tbl[i].efc, 8'd0, 1'b0);
        end

        // Stall held 20 cycles escalates after 16; escalation reloads the level.
        mid_reset();
        tag = "escalate";
        for (int i = 0; i < 20; i++) begin
            if (i < 16)
                step(0, 1, (i == 0) ? 2'd1 : 2'd2, 0, 2'd1, 2'd1, 16'd0, 8'd0, 1'b0);
            else
                step(0, 1, 2'd2, 0, 2'd2, 2'd2, 16'd1, 8'd1, 1'b0);
        end
        step(0, 0, 2'd0, 1, 2'd3, 2'd2, 16'd1, 8'd1, 1'b0);

        // Stall interrupted by a flush request, then reset while flushing.
        mid_reset();
        tag = "stall2flush";
        step(0, 1, 2'd1, 0, 2'd1, 2'd1, 16'd0, 8'd0, 1'b0);
        step(0, 1, 2'd1, 0, 2'd1, 2'd1, 16'd0, 8'd0, 1'b0);
        step(1, 1, 2'd3, 0, 2'd2, 2'd3, 16'd1, 8'd0, 1'b0);
        tag = "rst mid-FLUSH";
        mid_reset();

        // Flush timeout: 32 FLUSH cycles, sticky error survives later flushes.
        tag = "timeout";
        step(1, 0, 2'd1, 0, 2'd2, 2'd1, 16'd1, 8'd0, 1'b0);
        for (int i = 1; i < 32; i++)
            step(0, 0, 2'd0, 0, 2'd2, 2'd1, 16'd1, 8'd0, 1'b0);
        step(0, 0, 2'd0, 0, 2'd3, 2'd1, 16'd1, 8'd0, 1'b1);
        for (int i = 1; i < 8; i++)
            step(0, 0, 2'd0, 0, 2'd3, 2'd1, 16'd1, 8'd0, 1'b1);
        step(0, 0, 2'd0, 0, 2'd0, 2'd0, 16'd1, 8'd0, 1'b1);
        tag = "sticky";
        step(1, 0, 2'd2, 0, 2'd2, 2'd2, 16'd2, 8'd0, 1'b1);
        step(0, 0, 2'd0, 1, 2'd3, 2'd2, 16'd2, 8'd0, 1'b1);
        for (int i = 1; i < 8; i++)
            step(0, 0, 2'd0, 1, 2'd3, 2'd2, 16'd2, 8'd0, 1'b1);
        step(0, 0, 2'd0, 0, 2'd0, 2'd0, 16'd2, 8'd0, 1'b1);
        step(0, 1, 2'd1, 0, 2'd1, 2'd1, 16'd2, 8'd0, 1'b1);
        tag = "rst mid-STALL";
        mid_reset();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
